// File: rtl/cache_l1_wb.sv
// Direct-mapped write-back, write-allocate L1 cache with a single-beat CPU port
// and a burst write-back / refill port toward the next memory level.
module cache_l1_wb #(
    parameter int DATA_W = 64,
    parameter int WORDS  = 16,
    parameter int LINES  = 128,
    parameter int TAG_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_hit,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_write,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int AW    = OFF_W + IDX_W;
    localparam int PAD_W = 32 - AW - TAG_W;

    // state   | meaning
    // IDLE    | accept requests, serve hits
    // WB      | write dirty victim line out, one beat per handshake
    // RF_REQ  | hold refill read request until accepted
    // RF_DATA | collect WORDS refill beats into the line
    // RESP    | merge pending store or return the loaded word
    typedef enum logic [2:0] {S_IDLE, S_WB, S_RF_REQ, S_RF_DATA, S_RESP} state_t;

    logic [DATA_W-1:0] r_data_arr [LINES*WORDS];
    logic [TAG_W-1:0]  r_tag_arr  [LINES];
    logic [LINES-1:0]  r_valid, r_dirty;

    state_t            r_state;
    logic [OFF_W-1:0]  r_beat;
    logic              r_write;
    logic [IDX_W-1:0]  r_idx;
    logic [TAG_W-1:0]  r_tag, r_vtag;
    logic [OFF_W-1:0]  r_off;
    logic [DATA_W-1:0] r_wdata;

    logic              r_resp_valid, r_resp_hit, r_mem_req_valid, r_mem_req_write;
    logic [DATA_W-1:0] r_resp_rdata, r_mem_wdata;
    logic [31:0]       r_mem_addr;

    logic [OFF_W-1:0]  w_off;
    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_hit, w_last, w_unused_addr;
    logic [OFF_W-1:0]  w_beat_nxt;
    logic [DATA_W-1:0] w_hit_rd, w_wb_rd0, w_wb_rdn, w_resp_rd;
    logic              w_we;
    logic [AW-1:0]     w_waddr;
    logic [DATA_W-1:0] w_wdat;

    assign w_off         = req_addr[OFF_W-1:0];
    assign w_idx         = req_addr[OFF_W +: IDX_W];
    assign w_tag         = req_addr[AW +: TAG_W];
    assign w_unused_addr = ^req_addr[31:AW+TAG_W];
    assign w_hit         = r_valid[w_idx] && (r_tag_arr[w_idx] == w_tag);
    assign w_last        = (r_beat == {OFF_W{1'b1}});
    assign w_beat_nxt    = r_beat + 1'b1;

    assign w_hit_rd  = r_data_arr[{w_idx, w_off}];
    assign w_wb_rd0  = r_data_arr[{w_idx, {OFF_W{1'b0}}}];
    assign w_wb_rdn  = r_data_arr[{r_idx, w_beat_nxt}];
    assign w_resp_rd = r_data_arr[{r_idx, r_off}];

    assign req_ready     = (r_state == S_IDLE);
    assign resp_valid    = r_resp_valid;
    assign resp_hit      = r_resp_hit;
    assign resp_rdata    = r_resp_rdata;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_req_write = r_mem_req_write;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;

    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdat  = '0;
        if (r_state == S_IDLE && req_valid && req_write && w_hit) begin
            w_we    = 1'b1;
            w_waddr = {w_idx, w_off};
            w_wdat  = req_wdata;
        end else if (r_state == S_RF_DATA && mem_rvalid) begin
            w_we    = 1'b1;
            w_waddr = {r_idx, r_beat};
            w_wdat  = mem_rdata;
        end else if (r_state == S_RESP && r_write) begin
            w_we    = 1'b1;
            w_waddr = {r_idx, r_off};
            w_wdat  = r_wdata;
        end
    end

    // Data and tag storage carry no reset; the valid bits alone decide what is live.
    always_ff @(posedge clk) begin
        if (w_we) r_data_arr[w_waddr] <= w_wdat;
        if (r_state == S_RF_DATA && mem_rvalid && w_last) r_tag_arr[r_idx] <= r_tag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_beat          <= '0;
            r_valid         <= '0;
            r_dirty         <= '0;
            r_write         <= 1'b0;
            r_idx           <= '0;
            r_tag           <= '0;
            r_vtag          <= '0;
            r_off           <= '0;
            r_wdata         <= '0;
            r_resp_valid    <= 1'b0;
            r_resp_hit      <= 1'b0;
            r_resp_rdata    <= '0;
            r_mem_req_valid <= 1'b0;
            r_mem_req_write <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_rdata <= '0;
            case (r_state)
                S_IDLE: if (req_valid) begin
                    r_write <= req_write;
                    r_idx   <= w_idx;
                    r_tag   <= w_tag;
                    r_off   <= w_off;
                    r_wdata <= req_wdata;
                    r_vtag  <= r_tag_arr[w_idx];
                    r_beat  <= '0;
                    if (w_hit) begin
                        r_resp_valid <= 1'b1;
                        r_resp_hit   <= 1'b1;
                        if (req_write) r_dirty[w_idx] <= 1'b1;
                        else           r_resp_rdata   <= w_hit_rd;
                    end else begin
                        // Line is invalid from here on so an abandoned miss leaves nothing live.
                        r_valid[w_idx]  <= 1'b0;
                        r_mem_req_valid <= 1'b1;
                        if (r_valid[w_idx] && r_dirty[w_idx]) begin
                            r_state         <= S_WB;
                            r_mem_req_write <= 1'b1;
                            r_mem_addr      <= {{PAD_W{1'b0}}, r_tag_arr[w_idx], w_idx, {OFF_W{1'b0}}};
                            r_mem_wdata     <= w_wb_rd0;
                        end else begin
                            r_state         <= S_RF_REQ;
                            r_mem_req_write <= 1'b0;
                            r_mem_addr      <= {{PAD_W{1'b0}}, w_tag, w_idx, {OFF_W{1'b0}}};
                        end
                    end
                end
                S_WB: if (mem_req_ready) begin
                    r_beat <= w_beat_nxt;
                    if (w_last) begin
                        r_state         <= S_RF_REQ;
                        r_mem_req_write <= 1'b0;
                        r_mem_addr      <= {{PAD_W{1'b0}}, r_tag, r_idx, {OFF_W{1'b0}}};
                    end else begin
                        r_mem_addr  <= {{PAD_W{1'b0}}, r_vtag, r_idx, w_beat_nxt};
                        r_mem_wdata <= w_wb_rdn;
                    end
                end
                S_RF_REQ: if (mem_req_ready) begin
                    r_mem_req_valid <= 1'b0;
                    r_beat          <= '0;
                    r_state         <= S_RF_DATA;
                end
                S_RF_DATA: if (mem_rvalid) begin
                    r_beat <= w_beat_nxt;
                    if (w_last) begin
                        r_valid[r_idx] <= 1'b1;
                        r_dirty[r_idx] <= 1'b0;
                        r_state        <= S_RESP;
                        r_resp_valid   <= 1'b1;
                        if (!r_write) r_resp_rdata <= (r_off == r_beat) ? mem_rdata : w_resp_rd;
                    end
                end
                S_RESP: begin
                    if (r_write) r_dirty[r_idx] <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_l1_wb.sv
// Directed bench for cache_l1_wb: hit table plus hand-written miss, write-back,
// stall, reset-abort and store-allocate sequences against a simple memory responder.
module tb_cache_l1_wb;
    logic        clk, rst_n;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid, resp_hit;
    logic [63:0] resp_rdata;
    logic        mem_req_valid, mem_req_ready, mem_req_write;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    int total = 0, bad = 0, cyc = 0;
    int n_wr = 0, n_rd = 0, refill_left = 0, beats_sent = 0, last_beat_cyc = 0, resp_cyc = 0;
    int stall_left = 0, stall_cycles = 0;
    logic        stall_arm = 1'b0;
    logic [31:0] refill_base = '0, rd_last = '0, snap_addr = '0;
    logic [63:0] snap_data = '0;
    logic [31:0] wr_addr_q[$];
    logic [63:0] wr_data_q[$];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic        exp_hit;
        logic [63:0] exp_rdata;
    } vec_t;
    vec_t vt[5];

    cache_l1_wb dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_write(mem_req_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Next-level memory: refill beat k of line base B returns 0xD0000000 + B + k.
    initial begin
        mem_req_ready = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                refill_left   = 0;
                stall_left    = 0;
                mem_rvalid    = 1'b0;
                mem_req_ready = 1'b0;
            end else begin
                if (refill_left > 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = 64'hD000_0000 + 64'(refill_base) + 64'(16 - refill_left);
                    refill_left--;
                    beats_sent++;
                    if (refill_left == 0) last_beat_cyc = cyc;
                end else begin
                    mem_rvalid = 1'b0;
                end
                if (stall_arm && mem_req_valid && mem_req_write && n_wr == 3) begin
                    stall_arm  = 1'b0;
                    stall_left = 5;
                    snap_addr  = mem_addr;
                    snap_data  = mem_wdata;
                end
                if (stall_left > 0) begin
                    if (stall_left < 5) begin
                        chk("stall_valid", 64'(mem_req_valid), 64'd1);
                        chk("stall_addr", 64'(mem_addr), 64'(snap_addr));
                        chk("stall_wdata", mem_wdata, snap_data);
                    end
                    mem_req_ready = 1'b0;
                    stall_left--;
                    stall_cycles++;
                end else begin
                    mem_req_ready = 1'b1;
                end
                if (mem_req_valid && mem_req_ready) begin
                    if (mem_req_write) begin
                        n_wr++;
                        wr_addr_q.push_back(mem_addr);
                        wr_data_q.push_back(mem_wdata);
                    end else begin
                        n_rd++;
                        rd_last     = mem_addr;
                        refill_base = mem_addr;
                        refill_left = 16;
                        beats_sent  = 0;
                    end
                end
            end
        end
    end

    task automatic do_req(input logic w, input logic [31:0] a, input logic [63:0] d,
                          output logic hit, output logic [63:0] rd, output int lat);
        int n;
        int t0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        t0 = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        n = 0;
        while (!resp_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!resp_valid) begin
            total++;
            bad++;
            $display("FAIL resp_timeout: no response for addr %0h", a);
        end
        hit      = resp_hit;
        rd       = resp_rdata;
        lat      = cyc - t0;
        resp_cyc = cyc;
        @(negedge clk);
        chk("resp_pulse", 64'(resp_valid), 64'd0);
    endtask

    initial begin
        logic        hit;
        logic [63:0] rd;
        int          lat, nw, nr, n;

        vt[0] = '{1'b1, 32'h0011, 64'hAAAA, 1'b1, 64'h0};
        vt[1] = '{1'b0, 32'h0011, 64'h0,    1'b1, 64'hAAAA};
        vt[2] = '{1'b0, 32'h0012, 64'h0,    1'b1, 64'hD000_0012};
        vt[3] = '{1'b0, 32'h001F, 64'h0,    1'b1, 64'hD000_001F};
        vt[4] = '{1'b0, 32'h0010, 64'h0,    1'b1, 64'hD000_0010};

        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_hit", 64'(resp_hit), 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);

        // Cold load miss.
        do_req(1'b0, 32'h0011, 64'h0, hit, rd, lat);
        chk("cold_hit", 64'(hit), 64'd0);
        chk("cold_rdata", rd, 64'hD000_0011);
        chk("cold_rd_reqs", 64'(n_rd), 64'd1);
        chk("cold_rd_addr", 64'(rd_last), 64'h10);
        chk("cold_wr_beats", 64'(n_wr), 64'd0);
        chk("cold_resp_after_last", 64'(resp_cyc - last_beat_cyc), 64'd1);

        // Hit table.
        for (int i = 0; i < 5; i++) begin
            nw = n_wr;
            nr = n_rd;
            do_req(vt[i].wr, vt[i].addr, vt[i].wdata, hit, rd, lat);
            chk($sformatf("vec%0d_hit", i), 64'(hit), 64'(vt[i].exp_hit));
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd1);
            chk($sformatf("vec%0d_mem_traffic", i), 64'((n_wr - nw) + (n_rd - nr)), 64'd0);
        end

        // Dirty eviction with a 5-cycle ready stall on write beat 3.
        wr_addr_q.delete();
        wr_data_q.delete();
        nw = n_wr;
        nr = n_rd;
        stall_cycles = 0;
        stall_arm = 1'b1;
        do_req(1'b0, 32'h0811, 64'h0, hit, rd, lat);
        chk("evict_hit", 64'(hit), 64'd0);
        chk("evict_rdata", rd, 64'hD000_0811);
        chk("evict_wr_beats", 64'(n_wr - nw), 64'd16);
        chk("evict_rd_reqs", 64'(n_rd - nr), 64'd1);
        chk("evict_rd_addr", 64'(rd_last), 64'h810);
        chk("evict_stall_cycles", 64'(stall_cycles), 64'd5);
        for (int k = 0; k < 16 && k < wr_addr_q.size(); k++) begin
            chk($sformatf("wb_addr%0d", k), 64'(wr_addr_q[k]), 64'h10 + 64'(k));
            chk($sformatf("wb_data%0d", k), wr_data_q[k],
                (k == 1) ? 64'hAAAA : 64'hD000_0010 + 64'(k));
        end

        // Store miss to a clean line, reload, then evict to prove it went dirty.
        nw = n_wr;
        nr = n_rd;
        do_req(1'b1, 32'h0022, 64'h5, hit, rd, lat);
        chk("stmiss_hit", 64'(hit), 64'd0);
        chk("stmiss_rdata", rd, 64'd0);
        chk("stmiss_wr_beats", 64'(n_wr - nw), 64'd0);
        chk("stmiss_rd_addr", 64'(rd_last), 64'h20);
        do_req(1'b0, 32'h0022, 64'h0, hit, rd, lat);
        chk("stmiss_reload_hit", 64'(hit), 64'd1);
        chk("stmiss_reload_rdata", rd, 64'h5);
        wr_addr_q.delete();
        wr_data_q.delete();
        nw = n_wr;
        do_req(1'b0, 32'h0822, 64'h0, hit, rd, lat);
        chk("stmiss_evict_beats", 64'(n_wr - nw), 64'd16);
        if (wr_addr_q.size() > 2) begin
            chk("stmiss_evict_addr2", 64'(wr_addr_q[2]), 64'h22);
            chk("stmiss_evict_data2", wr_data_q[2], 64'h5);
        end
        chk("stmiss_evict_rdata", rd, 64'hD000_0822);

        // Reset during refill beat 7.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0033; req_wdata = '0;
        @(negedge clk);
        req_valid = 1'b0; req_addr = '0;
        n = 0;
        while (beats_sent != 8 && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("rst_mid_reached_beat7", 64'(beats_sent), 64'd8);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_req_ready", 64'(req_ready), 64'd1);
        chk("rst_mid_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_mid_mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_mid_mem_req_write", 64'(mem_req_write), 64'd0);
        chk("rst_mid_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mid_mem_wdata", mem_wdata, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        nr = n_rd;
        do_req(1'b0, 32'h0033, 64'h0, hit, rd, lat);
        chk("post_rst_hit", 64'(hit), 64'd0);
        chk("post_rst_rdata", rd, 64'hD000_0033);
        chk("post_rst_rd_reqs", 64'(n_rd - nr), 64'd1);
        do_req(1'b0, 32'h0811, 64'h0, hit, rd, lat);
        chk("post_rst_old_line_hit", 64'(hit), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
